// File: rtl/add32_arb_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
package add32_arb_pkg;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/add32_arbiter_add32.sv
// Plain 32-bit ripple-carry adder; purely combinational, shared by both requesters.
module add32
    import add32_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    // Carry ripples bit by bit from cin to cout.
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/add32_arbiter.sv
// Two requesters share one adder; a single result register with valid/ready
// on the response side. RR_EN=1 alternates under contention, RR_EN=0 favours req0.
//
// state | meaning
// EMPTY | result register holds nothing, resp_valid low
// FULL  | result register holds an unconsumed result, resp_valid high
module add32_arbiter
    import add32_arb_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_cin,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_cin,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_sum,
    output logic              resp_cout,
    output logic              resp_id
);

    state_t             state;
    logic               last_grant;
    logic [N_REQ-1:0]   valids;
    logic               grant;
    logic               accept;
    logic               fire;
    logic [DATA_W-1:0]  mux_a;
    logic [DATA_W-1:0]  mux_b;
    logic               mux_cin;
    logic [DATA_W-1:0]  add_sum;
    logic               add_cout;

    assign valids = {req1_valid, req0_valid};

    // Pick the winner from the valids only; operands never influence the grant.
    always_comb begin
        grant = 1'b0;
        if (&valids) begin
            grant = (RR_EN != 0) ? ~last_grant : 1'b0;
        end else if (valids[1]) begin
            grant = 1'b1;
        end
    end

    // Register can take a new result when empty or when its content leaves this cycle.
    // Reset gates the readys so nothing is offered while the block is held.
    always_comb begin
        accept     = !reset && ((state == EMPTY) || resp_ready);
        req0_ready = accept && valids[0] && !grant;
        req1_ready = accept && valids[1] && grant;
        fire       = req0_ready || req1_ready;
    end

    // Operand mux steered by the grant.
    always_comb begin
        mux_a   = grant ? req1_a   : req0_a;
        mux_b   = grant ? req1_b   : req0_b;
        mux_cin = grant ? req1_cin : req0_cin;
    end

    add32 u_add32 (
        .a    (mux_a),
        .b    (mux_b),
        .cin  (mux_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State, arbitration history and result register.
    // last_grant resets to 1 so requester 0 wins the first contended grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            resp_id    <= 1'b0;
        end else if (fire) begin
            state      <= FULL;
            last_grant <= grant;
            resp_sum   <= add_sum;
            resp_cout  <= add_cout;
            resp_id    <= grant;
        end else if ((state == FULL) && resp_ready) begin
            state <= EMPTY;
        end
    end

    assign resp_valid = (state == FULL);

endmodule

// File: tb/tb_add32_arbiter.sv
// Directed bench for add32_arbiter: one round-robin and one fixed-priority
// instance driven by the same stimulus.
module tb_add32_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_cin, req1_cin;
    logic        resp_ready;

    logic        r_ready0, r_ready1, r_valid, r_cout, r_id;
    logic [31:0] r_sum;
    logic        f_ready0, f_ready1, f_valid, f_cout, f_id;
    logic [31:0] f_sum;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        c0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        c1;
        logic [31:0] sum;
        logic        cout;
        logic        id;
    } vec_t;

    vec_t vecs[6];

    add32_arbiter #(.RR_EN(1)) dut_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(r_ready0), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(r_ready1), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .resp_valid(r_valid), .resp_ready(resp_ready), .resp_sum(r_sum), .resp_cout(r_cout), .resp_id(r_id)
    );

    add32_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(f_ready0), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(f_ready1), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .resp_valid(f_valid), .resp_ready(resp_ready), .resp_sum(f_sum), .resp_cout(f_cout), .resp_id(f_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0000_0009, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 32'h0000_0000, 1'b1, 1'b1};

        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = 32'h0; req0_b = 32'h0; req0_cin = 1'b0;
        req1_a = 32'h0; req1_b = 32'h0; req1_cin = 1'b0;
        resp_ready = 1'b1;

        // Reset state with both requesters asserting valid
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready0", r_ready0, 0);
        chk("reset_ready1", r_ready1, 0);
        chk("reset_valid", r_valid, 0);
        chk("reset_sum", r_sum, 32'h0);
        chk("reset_cout", r_cout, 0);
        chk("reset_id", r_id, 0);

        // Single-request vectors, back to back with resp_ready high
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_cin = vecs[i].c0;
            req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_cin = vecs[i].c1;
            #1;
            chk($sformatf("vec%0d_ready0", i), r_ready0, vecs[i].v0);
            chk($sformatf("vec%0d_ready1", i), r_ready1, vecs[i].v1);
            chk($sformatf("vec%0d_fp_ready1", i), f_ready1, vecs[i].v1);
            tick();
            chk($sformatf("vec%0d_valid", i), r_valid, 1);
            chk($sformatf("vec%0d_sum", i), r_sum, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), r_cout, vecs[i].cout);
            chk($sformatf("vec%0d_id", i), r_id, vecs[i].id);
            chk($sformatf("vec%0d_fp_sum", i), f_sum, vecs[i].sum);
        end

        // No requests with consumer ready: drain to EMPTY and stay there
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("drain_valid", r_valid, 0);
        tick();
        chk("idle_valid", r_valid, 0);

        // Contention from fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd1;  req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_cin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = logic'(i % 2);
            #1;
            chk($sformatf("rr%0d_ready0", i), r_ready0, !g);
            chk($sformatf("rr%0d_ready1", i), r_ready1, g);
            chk($sformatf("fp%0d_ready1", i), f_ready1, 0);
            chk($sformatf("fp%0d_ready0", i), f_ready0, 1);
            tick();
            chk($sformatf("rr%0d_id", i), r_id, g);
            chk($sformatf("rr%0d_sum", i), r_sum, g ? 32'd30 : 32'd2);
            chk($sformatf("fp%0d_id", i), f_id, 0);
            chk($sformatf("fp%0d_sum", i), f_sum, 32'd2);
        end

        // Backpressure: result held, nobody accepted
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_ready0", i), r_ready0, 0);
            chk($sformatf("bp%0d_ready1", i), r_ready1, 0);
            chk($sformatf("bp%0d_fp_ready0", i), f_ready0, 0);
            tick();
            chk($sformatf("bp%0d_valid", i), r_valid, 1);
            chk($sformatf("bp%0d_sum", i), r_sum, 32'd30);
            chk($sformatf("bp%0d_id", i), r_id, 1);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready0", r_ready0, 1);
        chk("bp_release_ready1", r_ready1, 0);
        tick();
        chk("bp_release_id", r_id, 0);
        chk("bp_release_sum", r_sum, 32'd2);

        // Reset while FULL and stalled: result discarded immediately
        resp_ready = 1'b0;
        tick();
        chk("pre_reset_valid", r_valid, 1);
        reset = 1'b1;
        #1;
        chk("midreset_valid", r_valid, 0);
        chk("midreset_fp_valid", f_valid, 0);
        chk("midreset_sum", r_sum, 32'h0);
        chk("midreset_ready0", r_ready0, 0);
        chk("midreset_ready1", r_ready1, 0);
        tick();
        reset = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("postreset_ready0", r_ready0, 1);
        chk("postreset_ready1", r_ready1, 0);
        tick();
        chk("postreset_id0", r_id, 0);
        chk("postreset_valid", r_valid, 1);
        tick();
        chk("postreset_id1", r_id, 1);
        chk("postreset_sum1", r_sum, 32'd30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
